// File: rtl/vector_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_mem_stage_pkg
//  Description : Shared types and helpers for the vector memory stage.
//                The hazard unit imports the same state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package vector_mem_stage_pkg;

   // Default lane count. The stage top takes its VECTOR_SIZE default from this.
   localparam int unsigned VEC_LANES  = 6;
   localparam int unsigned LANE_CNT_W = $clog2(VEC_LANES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mem_state_t;

   // Number of lanes touched by one access.
   function automatic int unsigned access_len(input logic is_scalar,
                                              input int unsigned lanes = VEC_LANES);
      return is_scalar ? 32'd1 : lanes;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vector_lane_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : vector_lane_assembler
//  Description : Load-result register. One byte lane is written per capture;
//                a scalar load clears the upper lanes when it is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module vector_lane_assembler #(
   parameter int DATA_WIDTH  = 8,
   parameter int VECTOR_SIZE = 6,
   parameter int LANE_W      = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cap_en_i,
   input  logic [LANE_W-1:0]                 cap_lane_i,
   input  logic [DATA_WIDTH-1:0]             cap_data_i,
   input  logic                              clr_upper_i,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0] read_data_o
);

   for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_q;

      // Capture has priority; clear only affects lanes above lane 0.
      always_ff @(posedge clk) begin
         if (reset) begin
            lane_q <= '0;
         end else if (cap_en_i && (cap_lane_i == LANE_W'(g))) begin
            lane_q <= cap_data_i;
         end else if (clr_upper_i && (g != 0)) begin
            lane_q <= '0;
         end
      end

      assign read_data_o[g*DATA_WIDTH +: DATA_WIDTH] = lane_q;
   end

endmodule
`default_nettype wire

// File: rtl/vector_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : vector_mem_stage
//  Description : Memory-access stage. Sequences scalar or vector loads and
//                stores one lane per cycle onto a byte-wide synchronous
//                memory and stalls the upstream pipeline while busy.
//  Revision    : 1.0  initial release
// ============================================================================
module vector_mem_stage
   import vector_mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int VECTOR_SIZE = VEC_LANES,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              valid_in,
   input  logic                              memRead,
   input  logic                              memWrite,
   input  logic                              isScalar,
   input  logic [ADDR_WIDTH-1:0]             address,
   input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] writeData,
   input  logic [DATA_WIDTH-1:0]             mem_rdata,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic                              mem_we,
   output logic [DATA_WIDTH-1:0]             mem_wdata,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0] readData,
   output logic                              done,
   output logic                              stall
);

   localparam int LANE_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

   mem_state_t                       state_q, state_d;
   logic [LANE_W-1:0]                lane_q, lane_d;
   logic [LANE_W-1:0]                last_q;
   logic [ADDR_WIDTH-1:0]            base_q;
   logic [DATA_WIDTH*VECTOR_SIZE-1:0] wdata_q;
   logic                             store_q;

   logic                             req;
   logic                             accept;
   logic                             cap_en;
   logic [LANE_W-1:0]                cap_lane;
   logic                             clr_upper;
   logic [DATA_WIDTH-1:0]            wlane [VECTOR_SIZE];

   // A request seen while reset is high must not stall or start an access.
   assign req = valid_in & (memRead | memWrite) & ~reset;

   for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_wlane
      assign wlane[g] = wdata_q[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // State and lane counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
      end
   end

   // Latch the request at accept; both-high op codes are treated as a store.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_q  <= '0;
         wdata_q <= '0;
         store_q <= 1'b0;
         last_q  <= '0;
      end else if (accept) begin
         base_q  <= address;
         wdata_q <= writeData;
         store_q <= memWrite;
         last_q  <= LANE_W'(access_len(isScalar, unsigned'(VECTOR_SIZE)) - 32'd1);
      end
   end

   // Next-state, memory port and load-capture control.
   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      done      = 1'b0;
      stall     = 1'b0;
      accept    = 1'b0;
      cap_en    = 1'b0;
      cap_lane  = '0;
      clr_upper = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               accept    = 1'b1;
               stall     = 1'b1;
               lane_d    = '0;
               clr_upper = isScalar & memRead & ~memWrite;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            stall     = 1'b1;
            mem_addr  = base_q + ADDR_WIDTH'(lane_q);
            // Gated by reset so an abort never lands one more write.
            mem_we    = store_q & ~reset;
            mem_wdata = wlane[lane_q];
            // Read data returns one cycle late, so it belongs to the previous lane.
            if (!store_q && (lane_q != '0)) begin
               cap_en   = 1'b1;
               cap_lane = lane_q - LANE_W'(1);
            end
            if (lane_q == last_q) begin
               state_d = store_q ? DONE : DRAIN;
            end else begin
               lane_d = lane_q + LANE_W'(1);
            end
         end
         DRAIN: begin
            stall    = 1'b1;
            cap_en   = 1'b1;
            cap_lane = last_q;
            state_d  = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   vector_lane_assembler #(
      .DATA_WIDTH  (DATA_WIDTH),
      .VECTOR_SIZE (VECTOR_SIZE),
      .LANE_W      (LANE_W)
   ) u_asm (
      .clk         (clk),
      .reset       (reset),
      .cap_en_i    (cap_en),
      .cap_lane_i  (cap_lane),
      .cap_data_i  (mem_rdata),
      .clr_upper_i (clr_upper),
      .read_data_o (readData)
   );

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_mem_stage
//  Description : Scoreboard bench for vector_mem_stage with a byte memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vector_mem_stage;

   localparam int DW = 8;
   localparam int VS = 6;
   localparam int AW = 16;
   localparam int VW = DW * VS;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_in, memRead, memWrite, isScalar;
   logic [AW-1:0] address;
   logic [VW-1:0] writeData;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [VW-1:0] readData;
   logic          done, stall;

   vector_mem_stage #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .memRead(memRead),
      .memWrite(memWrite), .isScalar(isScalar), .address(address),
      .writeData(writeData), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .readData(readData),
      .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   // Byte-wide synchronous memory model.
   logic [DW-1:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
   typedef struct { int cyc; logic [VW-1:0] rd; } dn_t;
   wr_t wq[$];
   dn_t dq[$];

   int            n_checks = 0;
   int            n_pass   = 0;
   int            busy_lo  = 1;
   int            busy_hi  = 0;
   bit            mon_en   = 1'b0;
   logic [VW-1:0] model_rd = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: stall window, idle port values, writes and done pulses.
   always @(negedge clk) begin
      if (mon_en) begin
         check("stall", stall, (cyc >= busy_lo && cyc <= busy_hi));
         if (!stall) begin
            check("idle_mem_we", mem_we, 0);
            check("idle_mem_addr", mem_addr, 0);
            check("idle_mem_wdata", mem_wdata, 0);
         end
         if (mem_we) begin
            check("write_expected", wq.size() != 0, 1);
            if (wq.size() != 0) begin
               wr_t w;
               w = wq.pop_front();
               check("wr_addr", mem_addr, w.addr);
               check("wr_data", mem_wdata, w.data);
               check("wr_cycle", cyc, w.cyc);
            end
         end
         if (done) begin
            check("done_expected", dq.size() != 0, 1);
            if (dq.size() != 0) begin
               dn_t d;
               d = dq.pop_front();
               check("done_cycle", cyc, d.cyc);
               check("readData", readData, d.rd);
            end
         end
      end
   end

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_within_bound", seen, 1);
      @(posedge clk); #1;
   endtask

   // Issue one access in IDLE, holding it until done like a frozen EX/MEM.
   task automatic issue(input bit ld, input bit st, input bit sc, input logic [AW-1:0] a,
                        input logic [VW-1:0] wd, input logic [VW-1:0] ld_val);
      int  acc, lat, n;
      wr_t w;
      dn_t d;
      n   = sc ? 1 : VS;
      acc = cyc;
      lat = st ? n + 1 : n + 2;
      busy_lo = acc;
      busy_hi = acc + lat - 1;
      if (st) begin
         for (int i = 0; i < n; i++) begin
            w.cyc  = acc + 1 + i;
            w.addr = a + AW'(i);
            w.data = wd[i*DW +: DW];
            wq.push_back(w);
         end
      end else begin
         model_rd = ld_val;
      end
      d.cyc = acc + lat;
      d.rd  = model_rd;
      dq.push_back(d);
      valid_in = 1'b1; memRead = ld; memWrite = st; isScalar = sc;
      address = a; writeData = wd;
      wait_done();
      valid_in = 1'b0; memRead = 1'b0; memWrite = 1'b0;
   endtask

   initial begin
      int  acc;
      wr_t w;
      reset = 1'b1; valid_in = 1'b0; memRead = 1'b0; memWrite = 1'b0;
      isScalar = 1'b0; address = '0; writeData = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_readData", readData, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      reset  = 1'b0;
      mon_en = 1'b1;

      issue(0, 1, 0, 16'h0010, 48'h665544332211, '0);          // vector store
      issue(1, 0, 0, 16'h0010, '0, 48'h665544332211);          // vector load
      issue(0, 1, 0, 16'h0020, 48'hFFFFFFFFFFFF, '0);          // fill 0x20.. with FF
      issue(1, 0, 0, 16'h0020, '0, 48'hFFFFFFFFFFFF);          // readData all FF
      issue(0, 1, 1, 16'h0003, 48'h0000000000A5, '0);          // mem[3] = A5
      issue(1, 0, 1, 16'h0003, '0, 48'h0000000000A5);          // scalar load clears upper
      issue(0, 1, 1, 16'h0040, 48'h123456789A5A, '0);          // scalar store lane 0 only
      issue(1, 0, 1, 16'h0040, '0, 48'h00000000005A);
      issue(0, 1, 0, 16'hFFFE, 48'h060504030201, '0);          // address wrap
      issue(1, 0, 0, 16'hFFFE, '0, 48'h060504030201);
      issue(1, 1, 1, 16'h0050, 48'h000000000077, '0);          // both high -> store

      // ALU-only instructions: no stall, no memory activity.
      valid_in = 1'b1; memRead = 1'b0; memWrite = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      issue(0, 1, 1, 16'h0060, 48'h0000000000C1, '0);          // back-to-back pair
      issue(0, 1, 1, 16'h0061, 48'h0000000000C2, '0);
      issue(1, 0, 1, 16'h0061, '0, 48'h0000000000C2);

      // Reset during lane 2 of a vector store.
      acc = cyc;
      busy_lo = acc;
      busy_hi = acc + 3;
      for (int i = 0; i < 2; i++) begin
         w.cyc  = acc + 1 + i;
         w.addr = 16'h0010 + AW'(i);
         w.data = 8'hA1 + DW'(i);
         wq.push_back(w);
      end
      valid_in = 1'b1; memRead = 1'b0; memWrite = 1'b1; isScalar = 1'b0;
      address = 16'h0010; writeData = 48'hA6A5A4A3A2A1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1; valid_in = 1'b0; memWrite = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_rd = '0;
      check("abort_stall", stall, 0);
      check("abort_mem_we", mem_we, 0);
      check("abort_done", done, 0);
      check("abort_readData", readData, 0);
      repeat (10) @(posedge clk);
      #1;
      check("abort_mem10", mem[16'h0010], 8'hA1);
      check("abort_mem11", mem[16'h0011], 8'hA2);
      check("abort_mem12", mem[16'h0012], 8'h33);
      check("mem_wrap_0000", mem[16'h0000], 8'h03);
      check("mem_0060", mem[16'h0060], 8'hC1);
      check("writes_outstanding", wq.size(), 0);
      check("dones_outstanding", dq.size(), 0);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
